// File: rtl/fb_mem_arbiter.sv
// fb_mem_arbiter: arbitrates a single-port synchronous frame-buffer SRAM
// between the display refresh reader and the line-drawing engine.
// Build macro FB_ARB_ROUND_ROBIN_EN: when defined, conflicts alternate
// strictly between the ports. Otherwise display has priority, and a
// starvation escape forces a draw grant.
//
// state      | meaning
// PRI_DISP   | display wins a conflict; starve counter tracks draw losses
// FORCE_DRAW | draw wins the next conflict, then back to PRI_DISP
module fb_mem_arbiter #(
  parameter int STARVE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        rst_,
  input  logic        disp_rts,
  output logic        disp_rtr,
  input  logic [16:0] disp_addr,
  output logic        disp_bcast_xfc,
  input  logic        draw_rts,
  output logic        draw_rtr,
  input  logic [16:0] draw_addr,
  input  logic [31:0] draw_wdata,
  input  logic [3:0]  draw_wr_op,
  output logic        draw_bcast_xfc,
  output logic [31:0] rdata,
  output logic        mem_en,
  output logic [16:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_we,
  input  logic [31:0] mem_rdata
);

  logic w_conflict;
  logic w_draw_pri;
  logic w_grant_draw;
  logic w_grant_disp;
  logic w_rd_xfer;

  logic        r_pend;
  logic        r_pend_draw;
  logic [31:0] r_rdata;

  // Grants are combinational; rst_ gates them so nothing is granted in reset.
  assign w_conflict   = disp_rts & draw_rts;
  assign w_grant_draw = rst_ & draw_rts & (~disp_rts | w_draw_pri);
  assign w_grant_disp = rst_ & disp_rts & ~w_grant_draw;

  assign disp_rtr = w_grant_disp;
  assign draw_rtr = w_grant_draw;

  assign mem_en    = w_grant_disp | w_grant_draw;
  assign mem_addr  = w_grant_draw ? draw_addr : (w_grant_disp ? disp_addr : 17'h0);
  assign mem_we    = w_grant_draw ? draw_wr_op : 4'b0000;
  assign mem_wdata = w_grant_draw ? draw_wdata : 32'h0;

  assign w_rd_xfer = mem_en & (mem_we == 4'b0000);

`ifdef FB_ARB_ROUND_ROBIN_EN
  logic r_rr_draw;

  assign w_draw_pri = r_rr_draw;

  // The loser of each conflict becomes the winner of the next one.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_rr_draw <= 1'b0;
    end else if (w_conflict) begin
      r_rr_draw <= w_grant_disp;
    end
  end
`else
  typedef enum logic {PRI_DISP, FORCE_DRAW} state_t;

  localparam logic [3:0] LP_STARVE_LAST = 4'(STARVE_LIMIT - 1);

  state_t     r_state;
  logic [3:0] r_starve;

  assign w_draw_pri = (r_state == FORCE_DRAW);

  // Priority FSM: count consecutive draw losses, escape to FORCE_DRAW on the limit.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_state  <= PRI_DISP;
      r_starve <= 4'h0;
    end else begin
      case (r_state)
        PRI_DISP: begin
          if (w_grant_draw || !draw_rts) begin
            r_starve <= 4'h0;
          end else begin
            if (r_starve == LP_STARVE_LAST) r_state <= FORCE_DRAW;
            if (r_starve != 4'hF) r_starve <= r_starve + 4'h1;
          end
        end
        FORCE_DRAW: begin
          if (w_grant_draw) begin
            r_state  <= PRI_DISP;
            r_starve <= 4'h0;
          end
        end
        default: begin
          r_state  <= PRI_DISP;
          r_starve <= 4'h0;
        end
      endcase
    end
  end

  logic w_unused_conflict;
  assign w_unused_conflict = w_conflict;
`endif

  // Read return tracking: one cycle after a read grant, broadcast SRAM data.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_pend      <= 1'b0;
      r_pend_draw <= 1'b0;
      r_rdata     <= 32'h0;
    end else begin
      r_pend      <= w_rd_xfer;
      r_pend_draw <= w_grant_draw;
      if (r_pend) r_rdata <= mem_rdata;
    end
  end

  assign rdata          = r_pend ? mem_rdata : r_rdata;
  assign disp_bcast_xfc = r_pend & ~r_pend_draw;
  assign draw_bcast_xfc = r_pend & r_pend_draw;

endmodule

// File: tb/tb_fb_mem_arbiter.sv
// Bench for fb_mem_arbiter: directed steps plus a random tail, with a
// reference arbitration model and a read-return scoreboard.
module tb_fb_mem_arbiter;

  localparam int STARVE_LIMIT = 8;
`ifdef FB_ARB_ROUND_ROBIN_EN
  localparam int EXP_RUN = 1;
`else
  localparam int EXP_RUN = STARVE_LIMIT;
`endif

  logic        clk = 1'b0;
  logic        rst_;
  logic        disp_rts, disp_rtr, disp_bcast_xfc;
  logic [16:0] disp_addr;
  logic        draw_rts, draw_rtr, draw_bcast_xfc;
  logic [16:0] draw_addr;
  logic [31:0] draw_wdata;
  logic [3:0]  draw_wr_op;
  logic [31:0] rdata;
  logic        mem_en;
  logic [16:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_we;
  logic [31:0] mem_rdata;

  fb_mem_arbiter #(.STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk(clk), .rst_(rst_),
    .disp_rts(disp_rts), .disp_rtr(disp_rtr), .disp_addr(disp_addr),
    .disp_bcast_xfc(disp_bcast_xfc),
    .draw_rts(draw_rts), .draw_rtr(draw_rtr), .draw_addr(draw_addr),
    .draw_wdata(draw_wdata), .draw_wr_op(draw_wr_op),
    .draw_bcast_xfc(draw_bcast_xfc),
    .rdata(rdata),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // SRAM model: 1-cycle read latency, byte-enable writes, 256 words aliased.
  logic [31:0] mem_arr [0:255];
  logic        mem_init;
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) mem_arr[i] <= 32'h1000_0000 + 32'(i) * 32'h0000_0101;
      mem_arr[8'h10] <= 32'hA5A5_A5A5;
    end else if (mem_en) begin
      if (mem_we == 4'b0000) mem_rdata <= mem_arr[mem_addr[7:0]];
      else for (int b = 0; b < 4; b++)
        if (mem_we[b]) mem_arr[mem_addr[7:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end

  typedef struct {
    logic        is_draw;
    logic [31:0] data;
  } exp_t;
  exp_t q[$];

  int n_pass  = 0;
  int n_total = 0;

  logic        m_force;
  int          m_lose;
  logic        m_rr_draw;
  logic [31:0] m_last;
  logic        track;
  int          run_disp;
  int          n_draw_runs;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_force   = 1'b0;
    m_lose    = 0;
    m_rr_draw = 1'b0;
    m_last    = 32'h0;
    q.delete();
  endtask

  task automatic drive(input logic d_rts, input logic [16:0] d_addr,
                       input logic w_rts, input logic [16:0] w_addr,
                       input logic [31:0] w_data, input logic [3:0] w_op);
    disp_rts   = d_rts;
    disp_addr  = d_addr;
    draw_rts   = w_rts;
    draw_addr  = w_addr;
    draw_wdata = w_data;
    draw_wr_op = w_op;
  endtask

  task automatic idle();
    drive(1'b0, 17'h0, 1'b0, 17'h0, 32'h0, 4'h0);
  endtask

  // Sample at the falling edge: check grants, memory port, and read returns.
  task automatic settle();
    logic        conflict, pri, gdraw, gdisp;
    logic [16:0] a;
    exp_t        e;
    exp_t        n;
    @(negedge clk);
    conflict = disp_rts && draw_rts;
`ifdef FB_ARB_ROUND_ROBIN_EN
    pri = m_rr_draw;
`else
    pri = m_force;
`endif
    gdraw = draw_rts && (!disp_rts || pri);
    gdisp = disp_rts && !gdraw;
    a     = gdraw ? draw_addr : disp_addr;
    chk("disp_rtr", 32'(disp_rtr), 32'(gdisp));
    chk("draw_rtr", 32'(draw_rtr), 32'(gdraw));
    chk("rtr_exclusive", 32'(disp_rtr & draw_rtr), 32'h0);
    chk("mem_en", 32'(mem_en), 32'(gdisp | gdraw));
    chk("mem_we", 32'(mem_we), gdraw ? 32'(draw_wr_op) : 32'h0);
    chk("mem_wdata", mem_wdata, gdraw ? draw_wdata : 32'h0);
    if (gdisp || gdraw) chk("mem_addr", 32'(mem_addr), 32'(a));
    if (q.size() != 0) begin
      e = q.pop_front();
      chk("disp_bcast", 32'(disp_bcast_xfc), 32'(!e.is_draw));
      chk("draw_bcast", 32'(draw_bcast_xfc), 32'(e.is_draw));
      chk("rdata", rdata, e.data);
      m_last = e.data;
    end else begin
      chk("disp_bcast_idle", 32'(disp_bcast_xfc), 32'h0);
      chk("draw_bcast_idle", 32'(draw_bcast_xfc), 32'h0);
      chk("rdata_hold", rdata, m_last);
    end
    if ((gdisp || gdraw) && !(gdraw && draw_wr_op != 4'h0)) begin
      n.is_draw = gdraw;
      n.data    = mem_arr[a[7:0]];
      q.push_back(n);
    end
    if (track && conflict) begin
      if (disp_rtr) run_disp++;
      else if (draw_rtr) begin
        chk("conflict_run", 32'(run_disp), 32'(EXP_RUN));
        run_disp = 0;
        n_draw_runs++;
      end
    end
`ifdef FB_ARB_ROUND_ROBIN_EN
    if (conflict) m_rr_draw = !gdraw;
`else
    if (m_force) begin
      if (gdraw) begin
        m_force = 1'b0;
        m_lose  = 0;
      end
    end else if (draw_rts && !gdraw) begin
      m_lose++;
      if (m_lose == STARVE_LIMIT) m_force = 1'b1;
    end else begin
      m_lose = 0;
    end
`endif
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    settle();
    advance();
  endtask

  initial begin
    rst_ = 1'b0;
    mem_init = 1'b1;
    track = 1'b0;
    run_disp = 0;
    n_draw_runs = 0;
    idle();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    disp_rts = 1'b1;
    draw_rts = 1'b1;
    #1;
    chk("rst_disp_rtr", 32'(disp_rtr), 32'h0);
    chk("rst_draw_rtr", 32'(draw_rtr), 32'h0);
    chk("rst_mem_en", 32'(mem_en), 32'h0);
    chk("rst_mem_we", 32'(mem_we), 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_bcast", 32'({disp_bcast_xfc, draw_bcast_xfc}), 32'h0);
    idle();
    @(posedge clk);
    #1;
    mem_init = 1'b0;
    rst_ = 1'b1;

    // Display read of 0x00010, data returns next cycle.
    drive(1'b1, 17'h00010, 1'b0, 17'h0, 32'h0, 4'h0);
    settle();
    chk("rd_grant", 32'({disp_rtr, mem_en}), 32'h3);
    advance();
    idle();
    settle();
    chk("rd_bcast", 32'(disp_bcast_xfc), 32'h1);
    chk("rd_data", rdata, 32'hA5A5_A5A5);
    advance();

    // Draw partial write, then read it back.
    drive(1'b0, 17'h0, 1'b1, 17'h01234, 32'hDEAD_BEEF, 4'b0011);
    settle();
    chk("wr_we", 32'(mem_we), 32'h3);
    chk("wr_wdata", mem_wdata, 32'hDEAD_BEEF);
    advance();
    idle();
    settle();
    chk("wr_no_bcast", 32'({disp_bcast_xfc, draw_bcast_xfc}), 32'h0);
    advance();
    drive(1'b0, 17'h0, 1'b1, 17'h01234, 32'h0, 4'h0);
    step();
    idle();
    settle();
    chk("wr_readback", rdata, 32'h1000_BEEF);
    advance();

    // Continuous contention: grant pattern.
    track = 1'b1;
    for (int i = 0; i < 36; i++) begin
      drive(1'b1, 17'h00040 + 17'(i), 1'b1, 17'h00080 + 17'(i), 32'h0, 4'h0);
      step();
    end
    track = 1'b0;
    chk("draw_grant_count", 32'(n_draw_runs), 32'(36 / (EXP_RUN + 1)));
    idle();
    step();

    // Four back-to-back display reads.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 17'h00020 + 17'(i), 1'b0, 17'h0, 32'h0, 4'h0);
      settle();
      if (i > 0) chk("b2b_bcast", 32'(disp_bcast_xfc), 32'h1);
      advance();
    end
    idle();
    settle();
    chk("b2b_bcast_last", 32'(disp_bcast_xfc), 32'h1);
    chk("b2b_data_last", rdata, 32'h1000_2323);
    advance();

    // Starve counter cleared by a draw_rts gap, then a long contention.
    for (int i = 0; i < 5; i++) begin drive(1'b1, 17'h1, 1'b1, 17'h2, 32'h0, 4'h0); step(); end
    drive(1'b1, 17'h3, 1'b0, 17'h0, 32'h0, 4'h0); step();
    for (int i = 0; i < 12; i++) begin drive(1'b1, 17'h4, 1'b1, 17'h5, 32'h1234_5678, 4'hF); step(); end

    // Escape state held while draw is idle, then draw wins at once.
    idle(); step();
    for (int i = 0; i < 8; i++) begin drive(1'b1, 17'h6, 1'b1, 17'h7, 32'h0, 4'h0); step(); end
    for (int i = 0; i < 3; i++) begin drive(1'b1, 17'h8, 1'b0, 17'h0, 32'h0, 4'h0); step(); end
    for (int i = 0; i < 2; i++) begin drive(1'b1, 17'h9, 1'b1, 17'hA, 32'h0, 4'h0); step(); end
    idle(); step();

    // Reset while a draw read is pending.
    drive(1'b0, 17'h0, 1'b1, 17'h00005, 32'h0, 4'h0);
    step();
    rst_ = 1'b0;
    drive(1'b1, 17'h1, 1'b1, 17'h2, 32'h0, 4'h0);
    #1;
    chk("mid_rst_rtr", 32'({disp_rtr, draw_rtr}), 32'h0);
    chk("mid_rst_bcast", 32'({disp_bcast_xfc, draw_bcast_xfc}), 32'h0);
    chk("mid_rst_rdata", rdata, 32'h0);
    #1;
    idle();
    rst_ = 1'b1;
    model_reset();
    settle();
    chk("post_rst_no_bcast", 32'(draw_bcast_xfc), 32'h0);
    chk("post_rst_rdata", rdata, 32'h0);
    advance();
    drive(1'b1, 17'h00010, 1'b0, 17'h0, 32'h0, 4'h0);
    settle();
    chk("post_rst_grant", 32'(disp_rtr), 32'h1);
    advance();
    idle();
    step();

    // Random traffic against the model.
    for (int i = 0; i < 300; i++) begin
      drive(1'($urandom_range(0, 1)), 17'($urandom),
            1'($urandom_range(0, 2) != 0), 17'($urandom), $urandom,
            ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom));
      step();
    end
    idle();
    step();
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
